// File: rtl/alu_multicycle_seq_if.sv
// Request/response bundle between decode, the iterative MUL/DIV/MOD sequencer and writeback.
interface alu_multicycle_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  logic             illegal_op;
  logic             busy;

  modport master (
    output in_valid, opcode, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, result_hi, div_by_zero, illegal_op, busy
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, out_ready,
    output in_ready, out_valid, result, result_hi, div_by_zero, illegal_op, busy
  );
endinterface

// File: rtl/alu_multicycle_seq.sv
// Iterative sequencer for MUL (shift-add) and DIV/MOD (restoring), one bit per cycle,
// holding the registered result until writeback accepts it.
module alu_multicycle_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_multicycle_seq_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL_RUN, ST_DIV_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {CL_MUL, CL_DIV, CL_MOD} op_class_t;

  state_t             state;
  op_class_t          op_class;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               out_valid_q;
  logic               div_by_zero_q;
  logic               illegal_op_q;
  logic               busy_q;

  logic               is_mul;
  logic               is_div;
  logic               is_mod;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH:0]     rem_sub;
  logic               iter_done;

  always_comb begin
    is_mul    = (bus.opcode == 5'b00011) || (bus.opcode == 5'b10100);
    is_div    = (bus.opcode == 5'b00100) || (bus.opcode == 5'b10101);
    is_mod    = (bus.opcode == 5'b00101);
    // Shifted partial remainder can reach 2*divisor-1, so compare and subtract at WIDTH+1 bits
    rem_sh    = {rem, dividend[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, divisor};
    rem_sub   = rem_sh - {1'b0, divisor};
    iter_done = (cnt == CNT_W'(WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_class      <= CL_MUL;
      cnt           <= '0;
      mcand         <= '0;
      acc           <= '0;
      mplier        <= '0;
      dividend      <= '0;
      divisor       <= '0;
      rem           <= '0;
      quo           <= '0;
      result_q      <= '0;
      result_hi_q   <= '0;
      out_valid_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
      illegal_op_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mcand    <= {{WIDTH{1'b0}}, bus.op_a};
            mplier   <= bus.op_b;
            acc      <= '0;
            dividend <= bus.op_a;
            divisor  <= bus.op_b;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            if (is_mul) begin
              op_class <= CL_MUL;
              state    <= ST_MUL_RUN;
            end else if (is_div || is_mod) begin
              op_class <= is_mod ? CL_MOD : CL_DIV;
              if (bus.op_b == '0) begin
                result_q      <= '1;
                result_hi_q   <= bus.op_a;
                div_by_zero_q <= 1'b1;
                out_valid_q   <= 1'b1;
                state         <= ST_DONE;
              end else begin
                state <= ST_DIV_RUN;
              end
            end else begin
              result_q     <= '0;
              result_hi_q  <= '0;
              illegal_op_q <= 1'b1;
              out_valid_q  <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end

        ST_MUL_RUN: begin
          if (iter_done) begin
            result_q    <= acc[WIDTH-1:0];
            result_hi_q <= acc[2*WIDTH-1:WIDTH];
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end

        ST_DIV_RUN: begin
          if (iter_done) begin
            result_q    <= (op_class == CL_MOD) ? rem : quo;
            result_hi_q <= (op_class == CL_MOD) ? '0 : rem;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            rem      <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo      <= {quo[WIDTH-2:0], rem_ge};
            dividend <= dividend << 1;
            cnt      <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            result_q      <= '0;
            result_hi_q   <= '0;
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            illegal_op_q  <= 1'b0;
            busy_q        <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_multicycle_seq.sv
// Directed vector bench for alu_multicycle_seq: table of operations plus backpressure and mid-run reset sequences.
module tb_alu_multicycle_seq;
  localparam int WIDTH = 16;
  localparam int NVEC  = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_multicycle_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_multicycle_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request, then scramble the operand inputs to show they are ignored while busy.
  task automatic issue(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.opcode   = opc;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 5'($urandom);
    bus.op_a     = 16'($urandom);
    bus.op_b     = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    string tag;
    logic [15:0] held;

    //          opcode     a        b        res      hi       dbz   ill   lat
    vecs[0]  = '{5'b00011, 16'd13,  16'd11,  16'd143, 16'd0,   1'b0, 1'b0, 17};
    vecs[1]  = '{5'b10100, 16'hFFFF,16'hFFFF,16'h0001,16'hFFFE,1'b0, 1'b0, 17};
    vecs[2]  = '{5'b00100, 16'd100, 16'd7,   16'd14,  16'd2,   1'b0, 1'b0, 17};
    vecs[3]  = '{5'b00101, 16'd100, 16'd7,   16'd2,   16'd0,   1'b0, 1'b0, 17};
    vecs[4]  = '{5'b00100, 16'h1234,16'd0,   16'hFFFF,16'h1234,1'b1, 1'b0, 0};
    vecs[5]  = '{5'b00001, 16'd5,   16'd6,   16'd0,   16'd0,   1'b0, 1'b1, 0};
    vecs[6]  = '{5'b10101, 16'hFFFF,16'd1,   16'hFFFF,16'd0,   1'b0, 1'b0, 17};
    vecs[7]  = '{5'b00100, 16'd5,   16'd9,   16'd0,   16'd5,   1'b0, 1'b0, 17};
    vecs[8]  = '{5'b00011, 16'h8000,16'd2,   16'h0000,16'h0001,1'b0, 1'b0, 17};
    vecs[9]  = '{5'b00101, 16'hFFFF,16'h8000,16'h7FFF,16'd0,   1'b0, 1'b0, 17};
    vecs[10] = '{5'b00101, 16'h0055,16'd0,   16'hFFFF,16'h0055,1'b1, 1'b0, 0};
    vecs[11] = '{5'b11111, 16'd9,   16'd0,   16'd0,   16'd0,   1'b0, 1'b1, 0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opcode    = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    rst_n         = 1'b0;
    #22;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      tag = $sformatf("v%0d", i);
      issue(vecs[i].opcode, vecs[i].a, vecs[i].b);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(lat);
      check({tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({tag, "_res"}, 32'(bus.result), 32'(vecs[i].res));
      check({tag, "_hi"},  32'(bus.result_hi), 32'(vecs[i].hi));
      check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(vecs[i].dbz));
      check({tag, "_ill"}, 32'(bus.illegal_op), 32'(vecs[i].ill));
      drain(tag);
    end

    // Backpressure: result must hold through 10 stalled cycles
    issue(5'b00100, 16'd100, 16'd7);
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd17);
    held = bus.result;
    check("bp_res", 32'(held), 32'd14);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_res", k),   32'(bus.result),    32'(held));
      check($sformatf("bp_hold%0d_ready", k), 32'(bus.in_ready),  32'd0);
      check($sformatf("bp_hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
    end
    drain("bp");

    // Asynchronous reset in the middle of a divide
    issue(5'b00100, 16'd100, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready),    32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("mid_rst_busy",      32'(bus.busy),        32'd0);
    check("mid_rst_result",    32'(bus.result),      32'd0);
    check("mid_rst_hi",        32'(bus.result_hi),   32'd0);
    check("mid_rst_dbz",       32'(bus.div_by_zero), 32'd0);
    check("mid_rst_ill",       32'(bus.illegal_op),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(5'b00011, 16'd3, 16'd5);
    wait_done(lat);
    check("post_rst_lat", 32'(lat), 32'd17);
    check("post_rst_res", 32'(bus.result), 32'd15);
    check("post_rst_hi",  32'(bus.result_hi), 32'd0);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
